// File: rtl/render_pkg.sv
// Shared render package: FSM state encoding and pixel packing width used by
// the dispatcher, the raymarcher and the renderer.
package render_pkg;

    // Frame dispatch states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } render_state_t;

    // Packed {R,G,B}, 8 bits per channel
    localparam int RGB_W = 24;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y counter: x runs 0..WIDTH-1, then y steps; wraps to (0,0)
// after the last pixel. last_out flags the final coordinate of the frame.
module raster_counter #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
) (
    input  logic                      clk_pixel_in,
    input  logic                      rst_in,
    input  logic                      clear_in,
    input  logic                      en_in,
    output logic [$clog2(WIDTH)-1:0]  x_out,
    output logic [$clog2(HEIGHT)-1:0] y_out,
    output logic                      last_out
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic          x_wrap;

    assign x_wrap   = (x_reg == X_LAST);
    assign last_out = x_wrap && (y_reg == Y_LAST);
    assign x_out    = x_reg;
    assign y_out    = y_reg;

    // Step one pixel per enable; clear restarts the raster at (0,0)
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in || clear_in) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (en_in) begin
            if (x_wrap) begin
                x_reg <= '0;
                y_reg <= last_out ? '0 : y_reg + 1'b1;
            end else begin
                x_reg <= x_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_dispatcher.sv
// Pixel dispatcher: issues raster-order coordinate requests to the raymarcher
// with a bounded number outstanding, and writes the in-order results to the
// frame buffer with a running address counter.
module pixel_dispatcher
    import render_pkg::*;
#(
    parameter int WIDTH        = 1280,
    parameter int HEIGHT       = 720,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                             clk_pixel_in,
    input  logic                             rst_in,
    input  logic                             start_in,
    input  logic                             continuous_in,
    output logic                             req_valid_out,
    input  logic                             req_ready_in,
    output logic [$clog2(WIDTH)-1:0]         req_x_out,
    output logic [$clog2(HEIGHT)-1:0]        req_y_out,
    input  logic                             res_valid_in,
    input  logic [RGB_W-1:0]                 res_rgb_in,
    output logic                             wr_en_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]  wr_addr_out,
    output logic [RGB_W-1:0]                 wr_data_out,
    output logic                             busy_out,
    output logic                             frame_done_out,
    output logic [7:0]                       frame_count_out,
    output logic                             err_out
);

    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [AW-1:0] ADDR_LAST    = AW'(WIDTH * HEIGHT - 1);
    localparam logic [IW-1:0] INFLIGHT_MAX = IW'(MAX_INFLIGHT);

    render_state_t  state_reg;
    logic [IW-1:0]  inflight_reg;
    logic [AW-1:0]  wr_cnt_reg;
    logic [AW-1:0]  wr_addr_reg;
    logic [RGB_W-1:0] wr_data_reg;
    logic           wr_en_reg;
    logic           err_reg;
    logic [7:0]     frame_count_reg;

    logic           req_hs;
    logic           res_accept;
    logic           frame_start;
    logic           raster_last;

    // Request valid depends only on registered state, never on ready
    assign req_valid_out = (state_reg == ISSUE) && (inflight_reg < INFLIGHT_MAX);
    assign req_hs        = req_valid_out && req_ready_in;
    // A result with nothing outstanding is a protocol error and is dropped
    assign res_accept    = res_valid_in && (inflight_reg != '0);
    assign frame_start   = (state_reg == IDLE) && (start_in || continuous_in);

    assign busy_out        = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign frame_done_out  = (state_reg == DONE);
    assign frame_count_out = frame_count_reg;
    assign err_out         = err_reg;
    assign wr_en_out       = wr_en_reg;
    assign wr_addr_out     = wr_addr_reg;
    assign wr_data_out     = wr_data_reg;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clk_pixel_in (clk_pixel_in),
        .rst_in       (rst_in),
        .clear_in     (frame_start),
        .en_in        (req_hs),
        .x_out        (req_x_out),
        .y_out        (req_y_out),
        .last_out     (raster_last)
    );

    // Frame sequencing; the frame counter steps as DONE is entered
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state_reg       <= IDLE;
            frame_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (frame_start) state_reg <= ISSUE;
                end
                ISSUE: begin
                    if (req_hs && raster_last) state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (res_accept && (wr_cnt_reg == ADDR_LAST)) begin
                        state_reg       <= DONE;
                        frame_count_reg <= frame_count_reg + 8'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outstanding-request count: up on issue, down on result, hold on both
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            inflight_reg <= '0;
        end else begin
            case ({req_hs, res_accept})
                2'b10:   inflight_reg <= inflight_reg + 1'b1;
                2'b01:   inflight_reg <= inflight_reg - 1'b1;
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    // Registered frame-buffer write; address is a running count since
    // results return in raster order
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            wr_cnt_reg  <= '0;
        end else begin
            wr_en_reg <= res_accept;
            if (res_accept) begin
                wr_addr_reg <= wr_cnt_reg;
                wr_data_reg <= res_rgb_in;
                wr_cnt_reg  <= wr_cnt_reg + 1'b1;
            end else if (frame_start) begin
                wr_cnt_reg  <= '0;
            end
        end
    end

    // Sticky error on an unexpected result
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            err_reg <= 1'b0;
        end else if (res_valid_in && (inflight_reg == '0)) begin
            err_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher on a 4x2 frame: a raymarcher model answers each
// handshake after a fixed latency, and a scoreboard holds the expected writes.
module tb_pixel_dispatcher;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int MI = 4;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int AW = $clog2(W * H);

    logic          clk_pixel_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          start_in = 1'b0;
    logic          continuous_in = 1'b0;
    logic          req_valid_out;
    logic          req_ready_in = 1'b1;
    logic [XW-1:0] req_x_out;
    logic [YW-1:0] req_y_out;
    logic          res_valid_in = 1'b0;
    logic [23:0]   res_rgb_in = '0;
    logic          wr_en_out;
    logic [AW-1:0] wr_addr_out;
    logic [23:0]   wr_data_out;
    logic          busy_out;
    logic          frame_done_out;
    logic [7:0]    frame_count_out;
    logic          err_out;

    always #5 clk_pixel_in = ~clk_pixel_in;

    pixel_dispatcher #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(MI)) dut (
        .clk_pixel_in    (clk_pixel_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .continuous_in   (continuous_in),
        .req_valid_out   (req_valid_out),
        .req_ready_in    (req_ready_in),
        .req_x_out       (req_x_out),
        .req_y_out       (req_y_out),
        .res_valid_in    (res_valid_in),
        .res_rgb_in      (res_rgb_in),
        .wr_en_out       (wr_en_out),
        .wr_addr_out     (wr_addr_out),
        .wr_data_out     (wr_data_out),
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out),
        .frame_count_out (frame_count_out),
        .err_out         (err_out)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } exp_t;

    typedef struct {
        int          due;
        logic [23:0] rgb;
    } pend_t;

    exp_t  sb[$];
    pend_t pend[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int wr_count = 0;
    int done_pulses = 0;
    int hold_left = 0;
    int max_gap = 0;
    int gap = 0;
    bit in_gap = 0;
    bit hold_started = 0;
    bit ret_en = 1;
    bit release_one = 0;
    bit start_pend = 0;
    bit stray_pend = 0;
    logic [23:0] stray_rgb = 24'hABCDEF;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rgb_of(input int x, input int y);
        return {8'(x * 37 + 5), 8'(y * 91 + 3), 8'(x * 16 + y + 1)};
    endfunction

    // One clock of stimulus and monitoring, done at the falling edge
    task automatic step();
        exp_t e;
        pend_t p;
        @(negedge clk_pixel_in);
        cyc++;
        start_in   = start_pend;
        start_pend = 0;
        res_valid_in = 1'b0;
        res_rgb_in   = '0;
        if (stray_pend) begin
            res_valid_in = 1'b1;
            res_rgb_in   = stray_rgb;
            stray_pend   = 0;
        end else if (pend.size() > 0 && ((ret_en && pend[0].due <= cyc) || release_one)) begin
            p = pend.pop_front();
            res_valid_in = 1'b1;
            res_rgb_in   = p.rgb;
            release_one  = 0;
        end
        if (hold_left > 0 && (hold_started || (req_valid_out && req_x_out == 2 && req_y_out == 1))) begin
            hold_started = 1;
            check_eq("hold_x", req_x_out, 2);
            check_eq("hold_y", req_y_out, 1);
            check_eq("hold_valid", req_valid_out, 1);
            req_ready_in = 1'b0;
            hold_left--;
        end else begin
            req_ready_in = 1'b1;
        end
        if (req_valid_out && req_ready_in && !rst_in) begin
            hs_count++;
            p.due = cyc + 3;
            p.rgb = rgb_of(int'(req_x_out), int'(req_y_out));
            pend.push_back(p);
            e.addr = AW'(int'(req_x_out) + W * int'(req_y_out));
            e.data = p.rgb;
            sb.push_back(e);
        end
        if (wr_en_out) begin
            wr_count++;
            $display("WR addr=%0d data=%06h", wr_addr_out, wr_data_out);
            if (sb.size() == 0) begin
                check_eq("wr_unexpected", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check_eq("wr_addr", wr_addr_out, e.addr);
                check_eq("wr_data", wr_data_out, e.data);
            end
        end
        if (frame_done_out) begin
            done_pulses++;
            in_gap = 1;
            gap = 0;
        end else if (in_gap) begin
            if (busy_out) begin
                if (gap > max_gap) max_gap = gap;
                in_gap = 0;
            end else begin
                gap++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, req_valid_out, 0);
        check_eq({tag, "_wr_en"}, wr_en_out, 0);
        check_eq({tag, "_wr_addr"}, wr_addr_out, 0);
        check_eq({tag, "_wr_data"}, wr_data_out, 0);
        check_eq({tag, "_busy"}, busy_out, 0);
        check_eq({tag, "_frame_done"}, frame_done_out, 0);
        check_eq({tag, "_frame_count"}, frame_count_out, 0);
        check_eq({tag, "_err"}, err_out, 0);
    endtask

    task automatic clear_model();
        pend.delete();
        sb.delete();
        hs_count = 0;
        wr_count = 0;
        done_pulses = 0;
        hold_left = 0;
        hold_started = 0;
        release_one = 0;
        stray_pend = 0;
        start_pend = 0;
        in_gap = 0;
        max_gap = 0;
        gap = 0;
    endtask

    task automatic do_reset(input string tag);
        rst_in = 1'b1;
        res_valid_in = 1'b0;
        continuous_in = 1'b0;
        clear_model();
        step();
        step();
        check_reset_outputs(tag);
        rst_in = 1'b0;
        clear_model();
    endtask

    task automatic run_until_done(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && done_pulses < target; i++) step();
        check_eq({tag, "_done_reached"}, done_pulses, target);
    endtask

    initial begin
        // Reset state
        do_reset("reset");

        // Single frame, fixed 3-cycle latency
        ret_en = 1;
        start_pend = 1;
        run_until_done("frame1", 1, 200);
        for (int i = 0; i < 6; i++) step();
        check_eq("frame1_writes", wr_count, 8);
        check_eq("frame1_done_once", done_pulses, 1);
        check_eq("frame1_count", frame_count_out, 1);
        check_eq("frame1_sb_empty", sb.size(), 0);
        check_eq("frame1_busy", busy_out, 0);
        check_eq("frame1_err", err_out, 0);

        // Start ignored outside IDLE: pulse mid-frame must not restart it
        do_reset("reset2");
        ret_en = 1;
        start_pend = 1;
        for (int i = 0; i < 4; i++) step();
        start_pend = 1;
        run_until_done("midstart", 1, 200);
        for (int i = 0; i < 6; i++) step();
        check_eq("midstart_writes", wr_count, 8);
        check_eq("midstart_done_once", done_pulses, 1);

        // Inflight limit with no results, then one result releases one slot
        do_reset("reset3");
        ret_en = 0;
        start_pend = 1;
        for (int i = 0; i < 20; i++) step();
        check_eq("limit_hs", hs_count, MI);
        check_eq("limit_valid_low", req_valid_out, 0);
        release_one = 1;
        for (int i = 0; i < 12; i++) step();
        check_eq("limit_hs_after_one", hs_count, MI + 1);
        check_eq("limit_valid_low2", req_valid_out, 0);
        check_eq("limit_one_write", wr_count, 1);
        ret_en = 1;

        // Ready held low at (2,1)
        do_reset("reset4");
        hold_left = 5;
        start_pend = 1;
        run_until_done("hold", 1, 200);
        for (int i = 0; i < 6; i++) step();
        check_eq("hold_consumed", hold_left, 0);
        check_eq("hold_writes", wr_count, 8);
        check_eq("hold_sb_empty", sb.size(), 0);

        // Stray result while IDLE
        do_reset("reset5");
        stray_pend = 1;
        for (int i = 0; i < 3; i++) step();
        check_eq("stray_err", err_out, 1);
        for (int i = 0; i < 10; i++) step();
        check_eq("stray_err_sticky", err_out, 1);
        check_eq("stray_no_write", wr_count, 0);
        do_reset("reset6");

        // Continuous mode, three frames
        continuous_in = 1'b1;
        for (int i = 0; i < 600 && done_pulses < 3; i++) begin
            step();
            if (done_pulses >= 3) continuous_in = 1'b0;
        end
        continuous_in = 1'b0;
        check_eq("cont_done_reached", done_pulses, 3);
        for (int i = 0; i < 6; i++) step();
        check_eq("cont_count", frame_count_out, 3);
        check_eq("cont_writes", wr_count, 24);
        check_eq("cont_gap_le1", (max_gap <= 1), 1);
        check_eq("cont_idle_after", busy_out, 0);

        // Reset during DRAIN with two outstanding, then a clean frame
        do_reset("reset7");
        start_pend = 1;
        for (int i = 0; i < 100 && !(hs_count == 8 && pend.size() == 1); i++) step();
        check_eq("drain_hs", hs_count, 8);
        check_eq("drain_busy", busy_out, 1);
        check_eq("drain_valid", req_valid_out, 0);
        rst_in = 1'b1;
        res_valid_in = 1'b0;
        clear_model();
        step();
        check_reset_outputs("midreset");
        rst_in = 1'b0;
        clear_model();
        start_pend = 1;
        run_until_done("after_reset", 1, 200);
        for (int i = 0; i < 6; i++) step();
        check_eq("after_reset_writes", wr_count, 8);
        check_eq("after_reset_count", frame_count_out, 1);
        check_eq("after_reset_sb_empty", sb.size(), 0);
        check_eq("after_reset_err", err_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
